// File: rtl/instr_encoder.sv
// RV32I field packer: one registered stage, valid/ready on both sides; flush clears the output stage.
// Latency 1 cycle, full throughput; output holds while stalled. IMM_RANGE_CHECK_EN adds immediate range errors.
module instr_encoder #(
   parameter int          CNT_W     = 16,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_opCode,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   input  logic [2:0]       in_fun3,
   input  logic [6:0]       in_fun7,
   input  logic [31:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic             out_err,
   output logic [CNT_W-1:0] enc_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_MEM    = 7'b0001111;
   localparam logic [6:0] OPC_SYS    = 7'b1110011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   logic [31:0] enc_word;
   logic        enc_illegal;
   logic        range_err;
   logic        is_shift;
   logic        take_in;
   logic        take_out;

   assign is_shift = (in_fun3 == 3'b001) || (in_fun3 == 3'b101);

   always_comb begin
      enc_word    = NOP_INSTR;
      enc_illegal = 1'b0;
      case (in_opCode)
         OPC_OP:
            enc_word = {in_fun7, in_rs2, in_rs1, in_fun3, in_rd, in_opCode};
         OPC_OP_IMM:
            if (is_shift)
               enc_word = {in_fun7, in_imm[4:0], in_rs1, in_fun3, in_rd, in_opCode};
            else
               enc_word = {in_imm[11:0], in_rs1, in_fun3, in_rd, in_opCode};
         OPC_LOAD, OPC_JALR, OPC_MEM, OPC_SYS:
            enc_word = {in_imm[11:0], in_rs1, in_fun3, in_rd, in_opCode};
         OPC_STORE:
            enc_word = {in_imm[11:5], in_rs2, in_rs1, in_fun3, in_imm[4:0], in_opCode};
         OPC_BRANCH:
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_fun3,
                        in_imm[4:1], in_imm[11], in_opCode};
         OPC_LUI, OPC_AUIPC:
            enc_word = {in_imm[31:12], in_rd, in_opCode};
         OPC_JAL:
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opCode};
         default: begin
            enc_word    = NOP_INSTR;
            enc_illegal = 1'b1;
         end
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   // Word is still encoded with truncation; this only flags immediates that lost bits.
   always_comb begin
      range_err = 1'b0;
      case (in_opCode)
         OPC_OP_IMM:
            if (is_shift)
               range_err = |in_imm[31:5];
            else
               range_err = in_imm != {{20{in_imm[11]}}, in_imm[11:0]};
         OPC_LOAD, OPC_JALR, OPC_MEM, OPC_SYS, OPC_STORE:
            range_err = in_imm != {{20{in_imm[11]}}, in_imm[11:0]};
         OPC_BRANCH:
            range_err = (in_imm != {{19{in_imm[12]}}, in_imm[12:0]}) || in_imm[0];
         OPC_JAL:
            range_err = (in_imm != {{11{in_imm[20]}}, in_imm[20:0]}) || in_imm[0];
         OPC_LUI, OPC_AUIPC:
            range_err = |in_imm[11:0];
         default:
            range_err = 1'b0;
      endcase
   end
`else
   assign range_err = 1'b0;
`endif

   assign in_ready = !out_valid || out_ready;
   // flush suppresses both handshakes in its cycle
   assign take_in  = in_valid && in_ready && !flush;
   assign take_out = out_valid && out_ready && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_err   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (take_in) begin
         out_valid <= 1'b1;
         out_instr <= enc_word;
         out_err   <= enc_illegal || range_err;
      end else if (take_out) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enc_count <= '0;
         err_count <= '0;
      end else if (take_out) begin
         if (enc_count != {CNT_W{1'b1}})
            enc_count <= enc_count + CNT_W'(1);
         if (out_err && (err_count != {CNT_W{1'b1}}))
            err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: hand-computed words, stall/flush/reset behaviour and counters.
module tb_instr_encoder;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  in_opCode;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [2:0]  in_fun3;
   logic [6:0]  in_fun7;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
   logic [15:0] enc_count;
   logic [15:0] err_count;

   int cnt_cmp;
   int cnt_fail;

   instr_encoder #(.CNT_W(16), .NOP_INSTR(32'h00000013)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_opCode (in_opCode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_fun3   (in_fun3),
      .in_fun7   (in_fun7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .enc_count (enc_count),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cnt_cmp++;
      assert (obs === exp) else begin
         cnt_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
      @(negedge clk);
      in_valid  = 1'b1;
      in_opCode = op;
      in_rd     = rd;
      in_rs1    = rs1;
      in_rs2    = rs2;
      in_fun3   = f3;
      in_fun7   = f7;
      in_imm    = imm;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      cnt_cmp   = 0;
      cnt_fail  = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_opCode = '0;
      in_rd     = '0;
      in_rs1    = '0;
      in_rs2    = '0;
      in_fun3   = '0;
      in_fun7   = '0;
      in_imm    = '0;
      #12;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_err", {31'd0, out_err}, 32'd0);
      check("rst_enc_count", {16'd0, enc_count}, 32'd0);
      check("rst_err_count", {16'd0, err_count}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // addi x1,x0,5
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5);
      check("addi_valid", {31'd0, out_valid}, 32'd1);
      check("addi_instr", out_instr, 32'h00500093);
      check("addi_err", {31'd0, out_err}, 32'd0);
      // add x3,x1,x2 then sw x2,8(x1) back-to-back
      send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0);
      check("add_instr", out_instr, 32'h002081B3);
      check("add_enc_count", {16'd0, enc_count}, 32'd1);
      send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
      check("sw_instr", out_instr, 32'h0020A423);
      check("sw_valid", {31'd0, out_valid}, 32'd1);
      check("sw_enc_count", {16'd0, enc_count}, 32'd2);
      idle();
      check("drain_valid", {31'd0, out_valid}, 32'd0);
      check("drain_instr_kept", out_instr, 32'h0020A423);
      check("drain_enc_count", {16'd0, enc_count}, 32'd3);

      send(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'hFFFFFFFC);
      check("beq_instr", out_instr, 32'hFE208EE3);
      send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00000800);
      check("jal_instr", out_instr, 32'h001000EF);
      send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000);
      check("lui_instr", out_instr, 32'h123452B7);
      // srai x1,x2,3
      send(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd3);
      check("srai_instr", out_instr, 32'h40315093);
      // lw x5,-1(x6)
      send(7'b0000011, 5'd5, 5'd6, 5'd0, 3'b010, 7'd0, 32'hFFFFFFFF);
      check("lw_instr", out_instr, 32'hFFF32283);
      check("lw_err", {31'd0, out_err}, 32'd0);
      idle();
      check("burst_enc_count", {16'd0, enc_count}, 32'd8);

      // stall: auipc x7,0x1000 held while out_ready=0, addi waiting behind it
      out_ready = 1'b0;
      send(7'b0010111, 5'd7, 5'd0, 5'd0, 3'b000, 7'd0, 32'h00001000);
      check("auipc_instr", out_instr, 32'h00001397);
      @(negedge clk);
      in_opCode = 7'b0010011;
      in_rd     = 5'd1;
      in_rs1    = 5'd0;
      in_fun3   = 3'b000;
      in_imm    = 32'd5;
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
         check("stall_instr_held", out_instr, 32'h00001397);
         check("stall_enc_count", {16'd0, enc_count}, 32'd8);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      check("unstall_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;
      check("unstall_instr", out_instr, 32'h00500093);
      check("unstall_enc_count", {16'd0, enc_count}, 32'd9);
      idle();
      check("unstall_drain_count", {16'd0, enc_count}, 32'd10);

      // illegal opcode
      send(7'h7F, 5'd1, 5'd2, 5'd3, 3'b111, 7'h7F, 32'hFFFFFFFF);
      check("illegal_instr", out_instr, 32'h00000013);
      check("illegal_err", {31'd0, out_err}, 32'd1);
      idle();
      check("illegal_err_count", {16'd0, err_count}, 32'd1);
      check("illegal_enc_count", {16'd0, enc_count}, 32'd11);

      // flush wins over both handshakes
      out_ready = 1'b0;
      send(7'h7F, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0);
      check("preflush_valid", {31'd0, out_valid}, 32'd1);
      @(negedge clk);
      flush     = 1'b1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_opCode = 7'b0010011;
      in_imm    = 32'd5;
      @(posedge clk);
      #1;
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_enc_count", {16'd0, enc_count}, 32'd11);
      check("flush_err_count", {16'd0, err_count}, 32'd1);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("flush_input_dropped", {31'd0, out_valid}, 32'd0);

      // addi x1,x0,4096: imm truncates to zero
      send(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4096);
      check("addi4096_instr", out_instr, 32'h00000093);
`ifdef IMM_RANGE_CHECK_EN
      check("addi4096_err", {31'd0, out_err}, 32'd1);
`else
      check("addi4096_err", {31'd0, out_err}, 32'd0);
`endif
      idle();

      // reset mid-stall
      out_ready = 1'b0;
      send(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000);
      check("prereset_valid", {31'd0, out_valid}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset_valid", {31'd0, out_valid}, 32'd0);
      check("midreset_instr", out_instr, 32'd0);
      check("midreset_err", {31'd0, out_err}, 32'd0);
      check("midreset_enc_count", {16'd0, enc_count}, 32'd0);
      check("midreset_err_count", {16'd0, err_count}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("postreset_valid", {31'd0, out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_fail);
      $finish;
   end

endmodule
